// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module   : instr_encoder_loader
// Purpose  : Packs decoded instruction fields into 8-bit words, buffers them
//            and writes them sequentially into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module instr_encoder_loader #(
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_in_opcode,
    input  logic [1:0]        i_in_ra1,
    input  logic [1:0]        i_in_ra2,
    input  logic              i_in_last,
    output logic              o_imem_wr_en,
    input  logic              i_imem_ready,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [7:0]        o_imem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_illegal,
    output logic              o_mem_full,
    output logic [ADDR_W:0]   o_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_TOT_W = ADDR_W + 2;

    localparam logic [c_TOT_W-1:0] c_CAP      = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [c_TOT_W-1:0] c_CAP_M1   = {2'b00, {ADDR_W{1'b1}}};
    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]    c_CNT_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_full;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_OCC_W-1:0]  r_occ;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic [ADDR_W:0]     r_count;

    logic                w_illegal;
    logic                w_no_ra1;
    logic [7:0]          w_packed;
    logic [c_TOT_W-1:0]  w_total;
    logic                w_in_ready;
    logic                w_hs;
    logic                w_push;
    logic                w_pop;
    logic                w_accept;
    logic                w_cap_hit;

    // 0110/0111 are illegal; 1000-1011 and 1110-1111 ignore reg_addr1.
    assign w_illegal = (i_in_opcode[3:1] == 3'b011);
    assign w_no_ra1  = i_in_opcode[3] && (i_in_opcode[3:1] != 3'b110);
    assign w_packed  = {i_in_opcode, (w_no_ra1 ? 2'b00 : i_in_ra1), i_in_ra2};

    // Words committed, buffered or in flight: the total promised to memory.
    assign w_total    = c_TOT_W'(r_count) + c_TOT_W'(r_occ) + c_TOT_W'(r_wr_en);
    assign w_in_ready = (r_state == S_LOAD) && (r_occ != c_OCC_FULL) && (w_total < c_CAP);
    assign w_hs       = i_in_valid && w_in_ready;
    assign w_push     = w_hs && !w_illegal;
    assign w_accept   = r_wr_en && i_imem_ready;
    assign w_pop      = (r_occ != '0) && (!r_wr_en || i_imem_ready);
    assign w_cap_hit  = w_push && (w_total == c_CAP_M1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_packed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_occ <= r_occ + c_OCC_W'(w_push) - c_OCC_W'(w_pop);
        end
    end

    // Address points at the word being (or next to be) written and
    // saturates at the last location instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_count <= '0;
            r_addr  <= '0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + c_CNT_ONE;
                if (r_addr != '1) begin
                    r_addr <= r_addr + c_ADDR_ONE;
                end
            end
            if (w_pop) begin
                r_wr_en <= 1'b1;
                r_wdata <= r_mem[r_rptr];
            end else if (w_accept) begin
                r_wr_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end
                        if (w_cap_hit) begin
                            r_full <= 1'b1;
                        end
                        if (i_in_last || w_cap_hit) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if ((r_occ == '0) && !r_wr_en) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_imem_wr_en  = r_wr_en;
    assign o_imem_addr   = r_addr;
    assign o_imem_wdata  = r_wdata;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err_illegal = r_err;
    assign o_mem_full    = r_full;
    assign o_count       = r_count;

endmodule

`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer-side counterpart of the 8-bit control-unit decoder.
- Accepts decoded instruction fields (opcode, two register addresses) over a valid/ready stream and packs each into the 8-bit format {opcode[7:4], reg_addr1[3:2], reg_addr2[1:0]}.
- Buffers packed words in a small FIFO and writes them sequentially into instruction memory through a write handshake.
- Used to load programs into the single-cycle core before release from reset/halt.

Parameters:
- ADDR_W, 4, instruction-memory address width; capacity = 2^ADDR_W words.
- FIFO_DEPTH, 4, packed-word buffer entries (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle pulse; begins a load session at address 0 (ignored unless IDLE).
- in_valid  input  1  field word valid.
- in_ready  output  1  block can accept a field word.
- in_opcode  input  4  opcode field.
- in_ra1  input  2  first register address.
- in_ra2  input  2  second register address / branch-jump target field.
- in_last  input  1  marks final word of the program (qualified by handshake).
- imem_wr_en  output  1  write request to instruction memory.
- imem_ready  input  1  memory accepts write this cycle.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  8  packed instruction.
- busy  output  1  high in LOAD or FLUSH.
- done  output  1  one-cycle pulse at session end.
- err_illegal  output  1  sticky; an illegal opcode was dropped this session.
- mem_full  output  1  sticky; capacity reached this session.
- count  output  ADDR_W+1  words committed to memory this session.

Behaviour:
- Reset values: in_ready=0, imem_wr_en=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err_illegal=0, mem_full=0, count=0; FIFO emptied; FSM=IDLE.
- Reset mid-session aborts immediately: no further writes occur and the partial program is not rolled back.
- FSM states and transitions:
  - IDLE -> LOAD on start. On entry, clear count, write pointer, err_illegal and mem_full.
  - LOAD -> FLUSH on a handshake with in_last=1, or when committed+queued reaches 2^ADDR_W (this also sets mem_full).
  - FLUSH -> DONE when the FIFO is empty and no write is outstanding.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- Handshake: transfer when in_valid && in_ready, sampled on the clock edge.
- in_ready = (state==LOAD) && FIFO not full && (count + fifo_occupancy + outstanding write) < 2^ADDR_W.
- Packing:
  - Opcodes 0000-0101 and 1100-1101: {op, ra1, ra2}.
  - Opcodes 1000, 1001, 1010, 1011, 1110, 1111 do not use reg_addr1: bits[3:2] are forced to 00.
  - Opcodes 0110 and 0111 are illegal: the word is consumed (handshake completes), not queued, sets err_illegal, and does not advance the address.
  - An illegal word carrying in_last still ends LOAD.
- Write port:
  - A word pushed at edge k may be popped at edge k+1 if it is at the FIFO head. imem_wr_en/addr/wdata are registered and valid from edge k+1 (minimum 1-cycle latency).
  - While imem_wr_en && !imem_ready, addr and wdata are held stable and no pop occurs.
  - On imem_wr_en && imem_ready: count and the address increment. The next FIFO entry is presented the following cycle with no bubble (back-to-back writes when imem_ready stays high).
- Address never wraps. The final legal address is 2^ADDR_W-1; capacity gating prevents overflow.
- Simultaneous push and pop on a full FIFO is not possible because in_ready is low. Push and pop in the same cycle on a non-full FIFO keeps occupancy constant.
- start while busy is ignored.

Test Plan:
- start, then add (op 0000, ra1=10, ra2=11, last=1) with imem_ready=1 -> imem_wdata=0x0B at addr 0, count=1, done pulses once, busy falls.
- mov R->Acc (op 1000, ra1=11, ra2=01), then j (op 1110, ra1=10, ra2=10) -> writes 0x81 at addr 0 and 0xE2 at addr 1 (ra1 zeroed in both).
- Sequence sub, illegal 0110, nor (last) -> writes 0x1x at addr 0 and 0x3x at addr 1; no write for the illegal word; err_illegal=1; count=2.
- imem_ready held low 5 cycles while feeding 6 words -> in_ready drops after FIFO_DEPTH queued + 1 outstanding; addr/wdata stable throughout; all 6 words written in order once ready returns.
- Stream 20 legal words with no in_last -> exactly 16 writes (addr 0-15), mem_full=1, in_ready low after the 16th acceptance, done pulses, count=16.
- Assert reset low mid-stream during a stalled write -> all outputs return to reset values asynchronously; after release, a new start resumes loading at addr 0.
